// File: rtl/cdb_scheduler_if.sv
// Requester-side handshake and common-data-bus lane signals for cdb_scheduler.
// Requesters drive the master modport. The scheduler uses the slave modport.
interface cdb_scheduler_if #(
  parameter int N     = 4,
  parameter int M     = 2,
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  localparam int unsigned SRC_W = $clog2(N);

  logic [N-1:0]       req_valid;
  logic [N*XLEN-1:0]  req_data;
  logic [N*TAG_W-1:0] req_tag;
  logic [N-1:0]       req_ready;
  logic [M-1:0]       cdb_valid;
  logic [M*XLEN-1:0]  cdb_data;
  logic [M*TAG_W-1:0] cdb_tag;
  logic [M*SRC_W-1:0] cdb_src;

  modport master (
    output req_valid, req_data, req_tag,
    input  req_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
  );

  modport slave (
    input  req_valid, req_data, req_tag,
    output req_ready, cdb_valid, cdb_data, cdb_tag, cdb_src
  );
endinterface

// File: rtl/cdb_scheduler.sv
// Grants up to M of N functional-unit results per cycle onto the common data bus lanes.
// Starving requesters are granted first. Lane outputs are registered.
module cdb_scheduler #(
  parameter int N          = 4,
  parameter int M          = 2,
  parameter int XLEN       = 32,
  parameter int TAG_W      = 5,
  parameter int STARVE_MAX = 7
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            flush,
  cdb_scheduler_if.slave  bus
);
  localparam int unsigned SRC_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] wait_cnt [N];
  logic [N-1:0]     starving;
  logic [N-1:0]     grant;
  logic [M-1:0]     lane_use;
  logic [SRC_W-1:0] lane_src  [M];
  logic [XLEN-1:0]  lane_data [M];
  logic [TAG_W-1:0] lane_tag  [M];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      starving[i] = bus.req_valid[i] && (wait_cnt[i] == CNT_MAX);
    end
  end

  // Pass 0 walks the starving requesters. Pass 1 walks the rest. Both passes go highest index first.
  always_comb begin : arb
    int n_grant;
    grant    = '0;
    lane_use = '0;
    n_grant  = 0;
    for (int k = 0; k < M; k++) begin
      lane_src[k]  = '0;
      lane_data[k] = '0;
      lane_tag[k]  = '0;
    end
    if (reset_n && !flush) begin
      for (int pass = 0; pass < 2; pass++) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (bus.req_valid[i] && (starving[i] == (pass == 0)) && (n_grant < M)) begin
            grant[i] = 1'b1;
            for (int k = 0; k < M; k++) begin
              if (k == n_grant) begin
                lane_use[k]  = 1'b1;
                lane_src[k]  = SRC_W'(i);
                lane_data[k] = bus.req_data[i*XLEN +: XLEN];
                lane_tag[k]  = bus.req_tag[i*TAG_W +: TAG_W];
              end
            end
            n_grant = n_grant + 1;
          end
        end
      end
    end
  end

  assign bus.req_ready = grant;

  // A counter clears on a transfer, when its request is idle, or on a flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (flush || !bus.req_valid[i] || grant[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != CNT_MAX) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // An invalid lane keeps its last payload. Consumers qualify the payload with cdb_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.cdb_valid <= '0;
      bus.cdb_data  <= '0;
      bus.cdb_tag   <= '0;
      bus.cdb_src   <= '0;
    end else begin
      bus.cdb_valid <= lane_use;
      for (int k = 0; k < M; k++) begin
        if (lane_use[k]) begin
          bus.cdb_data[k*XLEN +: XLEN]   <= lane_data[k];
          bus.cdb_tag[k*TAG_W +: TAG_W]  <= lane_tag[k];
          bus.cdb_src[k*SRC_W +: SRC_W]  <= lane_src[k];
        end
      end
    end
  end
endmodule

// File: doc/cdb_scheduler.md
CDB_SCHEDULER -- requirements
Module: cdb_scheduler

Interface
REQ-001 SHALL have parameter N, default 4: number of requesting functional units (N >= 2).
REQ-002 SHALL have parameter M, default 2: number of common data bus lanes (1 <= M <= N).
REQ-003 SHALL have parameter XLEN, default 32: result data width.
REQ-004 SHALL have parameter TAG_W, default 5: ROB/reservation tag width.
REQ-005 SHALL have parameter STARVE_MAX, default 7: wait-cycle threshold for starvation promotion (>= 1).
REQ-006 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port flush  input  1  synchronous pipeline flush (mispredict/exception).
REQ-009 SHALL have port req_valid  input  N  requester i holds a result.
REQ-010 SHALL have port req_data  input  N*XLEN  result of requester i in bits [i*XLEN +: XLEN].
REQ-011 SHALL have port req_tag  input  N*TAG_W  destination tag of requester i.
REQ-012 SHALL have port req_ready  output  N  requester i's result is accepted this cycle.
REQ-013 SHALL have port cdb_valid  output  M  lane k carries a valid broadcast.
REQ-014 SHALL have port cdb_data  output  M*XLEN  lane k result.
REQ-015 SHALL have port cdb_tag  output  M*TAG_W  lane k tag.
REQ-016 SHALL have port cdb_src  output  M*$clog2(N)  index of the requester that drove lane k.

Function
REQ-017 SHALL transfer requester i's result on a cycle where req_valid[i] and req_ready[i] are both 1.
REQ-018 SHALL drive req_ready combinationally from the current req_valid and internal wait counters, with no dependence on req_data or req_tag.
REQ-019 SHALL assert req_ready[i] only when req_valid[i] is 1.
REQ-020 SHALL assert at most M bits of req_ready per cycle.
REQ-021 SHALL assert exactly min(M, popcount(req_valid)) bits of req_ready per cycle when flush is 0.
REQ-022 SHALL form the priority order as follows: starving requesters (wait_cnt == STARVE_MAX) first, highest index first; then non-starving requesters, highest index first.
REQ-023 SHALL assign the j-th granted requester in that order to lane j; lanes above the grant count stay empty.
REQ-024 SHALL keep one wait counter per requester, width $clog2(STARVE_MAX+1), with reset value 0.
REQ-025 SHALL increment a requester's wait counter, saturating at STARVE_MAX, when req_valid=1 and req_ready=0.
REQ-026 SHALL clear a requester's wait counter on transfer or when req_valid=0.
REQ-027 SHALL register the lane outputs with one-cycle latency: a transfer in cycle t appears on cdb_valid/data/tag/src in cycle t+1.
REQ-028 SHALL hold each lane valid for exactly one cycle per transfer.
REQ-029 SHALL leave cdb_data/cdb_tag/cdb_src of an invalid lane at their previous values; consumers qualify them with cdb_valid.
REQ-030 SHALL drive all req_ready to 0 when flush=1.
REQ-031 SHALL, when flush=1, clear all cdb_valid bits and all wait counters at the next edge; a broadcast already on the lanes during the flush cycle remains visible for that cycle.
REQ-032 SHALL require each requester to hold req_valid, req_data and req_tag stable until transfer, or until it drops them on flush; holding them stable is a requester obligation, and the block does not check it.
REQ-033 SHALL resolve ties among multiple starving requesters by index order alone (highest index first); when more than M requesters starve, the unserved ones keep their saturated counters and are served in later cycles.

Reset
REQ-034 SHALL, while reset_n=0, asynchronously force cdb_valid=0, cdb_data=0, cdb_tag=0, cdb_src=0 and all wait counters to 0.
REQ-035 SHALL drive req_ready to 0 while reset_n=0.
REQ-036 SHALL, when reset_n is asserted mid-operation, discard any in-flight lane contents with no broadcast in the first cycle after reset release.
REQ-037 SHALL accept requests starting from the first rising edge after reset_n deasserts.

Verification
REQ-038 SHALL be verified for: N=4, M=2, req_valid=4'b1011 -> req_ready=4'b1010; next cycle lane0 src=3, lane1 src=1, both cdb_valid=1.
REQ-039 SHALL be verified for: N=4, M=2, req_valid=4'b0100 only -> req_ready=4'b0100; next cycle cdb_valid=2'b01 with lane0 tag equal to req_tag[2].
REQ-040 SHALL be verified for: starvation, with N=4, M=1, STARVE_MAX=3, requesters 3 and 0 valid continuously -> requester 0 is granted on the 4th cycle after its counter reaches 3, requester 3 is granted in all other cycles, and requester 0's counter resets after its grant.
REQ-041 SHALL be verified for: flush asserted with all requesters valid -> req_ready=0 that cycle; next cycle cdb_valid=0 and all wait counters=0.
REQ-042 SHALL be verified for: reset_n pulled low asynchronously mid-clock while lanes are valid -> cdb_valid=0 immediately, with no broadcast in the first cycle after release.
REQ-043 SHALL be verified for: random traffic across N in {2,4,8} and M in {1,2,N} -> every transferred tag appears exactly once on a lane one cycle later, and no requester waits more than STARVE_MAX+N cycles.
